// File: rtl/flash_pkg.sv
// Shared definitions for the boot flash loader: FSM encoding and flash interface widths.
// No logic; latency and backpressure are properties of the modules that import this.
package flash_pkg;

    localparam int         FA_W          = 24;
    localparam int         BC_W          = 14;
    localparam logic [7:0] FLASH_READ_OP = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_START,
        ST_RECV,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/flash_loader_packer.sv
// Little-endian 8-to-16 packer with its own word-address counter; write issued the cycle after the high byte.
// Latency: one cycle byte-to-write; no backpressure (at most one write per two input bytes).
module byte_packer #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          abort,
    input  logic          byte_vld,
    input  logic [7:0]    byte_dat,
    input  logic          flush,
    output logic          pending,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata
);

    logic [AW-1:0] dst;
    logic [7:0]    low;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst       <= '0;
            low       <= '0;
            pending   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                dst     <= start_addr;
                pending <= 1'b0;
            end else if (abort) begin
                // A half word left over after a timeout is dropped, not written.
                pending <= 1'b0;
            end else if (byte_vld) begin
                if (pending) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= dst;
                    mem_wdata <= {byte_dat, low};
                    dst       <= dst + 1'b1;
                    pending   <= 1'b0;
                end else begin
                    low     <= byte_dat;
                    pending <= 1'b1;
                end
            end else if (flush && pending) begin
                mem_we    <= 1'b1;
                mem_addr  <= dst;
                mem_wdata <= {8'h00, low};
                dst       <= dst + 1'b1;
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/flash_loader.sv
// Boot copy engine: splits a load into flash bursts of at most CHUNK bytes and packs the stream into BRAM words.
// Latency: done 1 cycle after the last byte (2 if a flush is needed); no backpressure, flash pacing via fl_rdy.
module flash_loader
    import flash_pkg::*;
#(
    parameter int DST_AW      = 12,
    parameter int CHUNK       = 4096,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [FA_W-1:0]   load_src,
    input  logic [DST_AW-1:0] load_dst,
    input  logic [23:0]       load_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [FA_W-1:0]   fl_addr,
    output logic [BC_W-1:0]   fl_byte_count,
    output logic              fl_start,
    output logic              fl_rst_n,
    input  logic              fl_rdy,
    input  logic [7:0]        fl_data,
    input  logic              fl_data_valid,
    output logic              mem_we,
    output logic [DST_AW-1:0] mem_addr,
    output logic [15:0]       mem_wdata
);

    localparam int              WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [23:0]     CHUNK_LEN = 24'(CHUNK);

    state_t          state, state_nxt;
    logic [FA_W-1:0] src;
    logic [23:0]     remaining;
    logic [BC_W-1:0] burst_left;
    logic [BC_W-1:0] chunk;
    logic [WD_W-1:0] wdog;
    logic            accept, take_byte, wd_run, timeout, pending;

    assign accept    = (state == ST_IDLE) && load_req && (load_len != '0);
    assign take_byte = (state == ST_RECV) && fl_data_valid;
    assign wd_run    = (state == ST_WAIT_RDY) || (state == ST_RECV);
    assign timeout   = wd_run && !fl_data_valid && (wdog == WD_LAST);
    assign chunk     = (remaining > CHUNK_LEN) ? BC_W'(CHUNK) : remaining[BC_W-1:0];

    assign busy     = (state == ST_WAIT_RDY) || (state == ST_START) ||
                      (state == ST_RECV) || (state == ST_FLUSH);
    assign done     = (state == ST_DONE);
    assign fl_start = (state == ST_START);
    assign fl_rst_n = ~reset;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (load_req) state_nxt = (load_len == '0) ? ST_DONE : ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (timeout)     state_nxt = ST_DONE;
                else if (fl_rdy) state_nxt = ST_START;
            end
            ST_START:    state_nxt = ST_RECV;
            ST_RECV: begin
                if (timeout) begin
                    state_nxt = ST_DONE;
                end else if (take_byte && (burst_left == BC_W'(1))) begin
                    // pending is the state before this byte: set means this byte completes a word.
                    if (remaining != 24'd1) state_nxt = ST_WAIT_RDY;
                    else if (pending)       state_nxt = ST_DONE;
                    else                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH:    state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            src           <= '0;
            remaining     <= '0;
            burst_left    <= '0;
            wdog          <= '0;
            error         <= 1'b0;
            fl_addr       <= '0;
            fl_byte_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src       <= load_src;
                remaining <= load_len;
            end
            if ((state == ST_IDLE) && load_req) error <= 1'b0;
            else if (timeout)                   error <= 1'b1;
            if ((state == ST_WAIT_RDY) && fl_rdy && !timeout) begin
                fl_addr       <= src;
                fl_byte_count <= chunk;
            end
            if (state == ST_START) begin
                burst_left <= fl_byte_count;
            end else if (take_byte) begin
                burst_left <= burst_left - 1'b1;
                remaining  <= remaining - 1'b1;
                src        <= src + 1'b1;
            end
            // START is outside wd_run, so the count restarts from zero for every burst.
            wdog <= (wd_run && !fl_data_valid) ? wdog + 1'b1 : '0;
        end
    end

    byte_packer #(.AW(DST_AW)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .start      (accept),
        .start_addr (load_dst),
        .abort      (timeout),
        .byte_vld   (take_byte),
        .byte_dat   (fl_data),
        .flush      (state == ST_FLUSH),
        .pending    (pending),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time copy engine sitting between the SPI flash reader and an on-chip BRAM.
- Takes a load request (flash source address, destination word address, byte length) and splits it into read bursts of at most CHUNK bytes.
- Drives the flash reader's start/addr/byte_count handshake and consumes its byte stream.
- Packs bytes little-endian into 16-bit words and writes them to the BRAM port; reports done or timeout error.

Parameters:
- DST_AW, 12, destination word-address width.
- CHUNK, 4096, maximum bytes per flash burst; must be even and in 2..16383.
- TIMEOUT_CYC, 65535, maximum clk cycles allowed without a byte while a burst is outstanding.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_req  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- load_src  in  24  flash byte address, sampled on an accepted load_req.
- load_dst  in  DST_AW  first destination word address, sampled on an accepted load_req.
- load_len  in  24  total byte count, sampled on an accepted load_req.
- busy  out  1  high from the cycle after acceptance until DONE is entered.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky timeout flag; cleared by the next accepted load_req.
- fl_addr  out  24  burst start address to the flash reader.
- fl_byte_count  out  14  burst length to the flash reader.
- fl_start  out  1  one-cycle start pulse.
- fl_rdy  in  1  flash reader idle and able to accept a start.
- fl_data  in  8  byte from the flash reader.
- fl_data_valid  in  1  fl_data is valid this cycle.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  DST_AW  BRAM word address.
- mem_wdata  out  16  BRAM write data; {high byte, low byte}.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. The top level drives the flash reader's active-low reset from ~reset.
- Reset asserted mid-load aborts immediately. No memory write is issued after reset assertion.
- States: IDLE, WAIT_RDY, START, RECV, FLUSH, DONE.
- IDLE:
  - load_req with load_len = 0 -> DONE directly; no flash traffic, no writes.
  - load_req with load_len > 0 -> latch src, dst, remaining = load_len; clear error; go to WAIT_RDY.
- WAIT_RDY:
  - chunk = min(remaining, CHUNK).
  - When fl_rdy = 1: register fl_addr = src, fl_byte_count = chunk; go to START.
- START:
  - fl_start = 1 for exactly this cycle; fl_addr and fl_byte_count are stable from this cycle until the burst ends.
  - burst_left = chunk; go to RECV.
- RECV, on each fl_data_valid:
  - If no byte is pending: hold fl_data in the low byte; set pending.
  - If a byte is pending: write {fl_data, low byte} at the current dst, registered, so mem_we is asserted the next cycle. Then dst += 1 (wraps modulo 2^DST_AW) and clear pending.
  - Also on each fl_data_valid: burst_left -= 1, remaining -= 1, src += 1.
- End of burst (burst_left reaches 0):
  - remaining > 0 -> WAIT_RDY.
  - remaining = 0 and pending -> FLUSH.
  - remaining = 0 and not pending -> DONE.
  - Because CHUNK is even, pending is set only at the end of the final burst.
- FLUSH: write {8'h00, low byte} at dst (mem_we high for one cycle); go to DONE.
- DONE: done = 1 for one cycle; busy drops the same cycle; go to IDLE.
- Timeout:
  - The watchdog counts cycles in WAIT_RDY and RECV; it is cleared on every fl_data_valid and on entry to START.
  - On reaching TIMEOUT_CYC: set error, go to DONE. Any partial word is discarded, not flushed.
- fl_data_valid outside RECV is ignored.
- src wraps modulo 2^24.
- mem_we throughput: at most one write per two bytes, so there is no back-pressure; the BRAM accepts a write every cycle.
- Completion latency: done is asserted 2 cycles after the last fl_data_valid for odd load_len, 1 cycle after for even load_len.

Decomposition:
- Shared package (flash_pkg): state encoding; flash read opcode constant 8'h03; byte-count width 14; flash address width 24.
- Sub-module byte_packer: 8-to-16 little-endian packer with flush input, write-enable output and address counter.
- The FSM, chunking and watchdog stay in flash_loader.

Test Plan:
- load_len = 6, src = 0x000100, dst = 0, flash bytes 11..16 -> writes (0,0x1211), (1,0x1413), (2,0x1615); done once; one fl_start with byte_count = 6.
- load_len = 5, bytes A1..A5 -> writes 0xA2A1, 0xA4A3, then FLUSH write 0x00A5 at dst+2; done 2 cycles after the last byte.
- CHUNK = 4, load_len = 10, src = 0x0000FE -> three bursts (addr 0x0FE/4, 0x102/4, 0x106/2); fl_start only when fl_rdy = 1; 5 contiguous word writes.
- load_len = 0 -> done pulse within 2 cycles; no fl_start, no mem_we; error = 0.
- TIMEOUT_CYC = 100, flash model stalls after 3 bytes -> error = 1 and done at cycle 100 of the stall; the partial byte is not written; the next load_req clears error.
- reset asserted mid-RECV with a byte pending; load_req pulsed while busy -> all outputs 0 asynchronously and no further mem_we; the mid-busy load_req is ignored, with no extra fl_start.
